conv_window_ctrl: RTL and testbench

Frame sequencer for the 3×3 sliding-window generator in the convolution path. It takes an unpadded feature-map pixel stream and feeds the window generator's `din/valid_in/repeat_in` inputs with a zero-padded frame: one pad row on top and bottom, one pad column on left and right. After the frame it issues the repeat/flush phase, counts emitted windows, and signals frame completion to the layer scheduler.

---
 rtl/conv_pkg.sv | 25 ++
 rtl/conv_pad_cnt.sv | 44 ++++
 rtl/conv_window_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_conv_window_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types, defaults and width helpers for the conv window controller
package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PAD_TOP = 3'd1,
        ST_BODY    = 3'd2,
        ST_PAD_BOT = 3'd3,
        ST_FLUSH   = 3'd4,
        ST_DRAIN   = 3'd5
    } conv_ctrl_state_t;

    localparam int M_DEF = 8;
    localparam int W_DEF = 480;
    localparam int H_DEF = 256;

    // Bits needed to encode values 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int ROW_W_DEF = cnt_width(H_DEF + 2);
    localparam int COL_W_DEF = cnt_width(W_DEF + 2);

endpackage

// File: rtl/conv_pad_cnt.sv
// rtl/conv_pad_cnt.sv - padded-frame row/column counter with wrap and last flags
module conv_pad_cnt
    import conv_pkg::*;
#(
    parameter int SP    = W_DEF + 2,
    parameter int RP    = H_DEF + 2,
    parameter int COL_W = COL_W_DEF,
    parameter int ROW_W = ROW_W_DEF
) (
    input  logic             clk,
    input  logic             Rst_n,
    input  logic             clr,
    input  logic             adv,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last_col,
    output logic             last_row
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SP - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(RP - 1);

    assign last_col = (col == COL_LAST);
    assign last_row = (row == ROW_LAST);

    // Column steps on each advance; wrapping the column bumps the row, and the last row wraps to 0.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (adv) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_window_ctrl.sv
// rtl/conv_window_ctrl.sv - zero-padding frame sequencer feeding the 3x3 window generator
module conv_window_ctrl
    import conv_pkg::*;
#(
    parameter int M         = M_DEF,
    parameter int W         = W_DEF,
    parameter int H         = H_DEF,
    parameter int FLUSH_LEN = W + 2
) (
    input  logic                           clk,
    input  logic                           Rst_n,
    input  logic                           start,
    input  logic                           abort,
    input  logic [M-1:0]                   s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    output logic [M-1:0]                   win_din,
    output logic                           win_valid,
    output logic                           win_repeat,
    input  logic                           win_valid_out,
    output logic                           busy,
    output logic                           done,
    output logic [cnt_width(H+2)-1:0]      row_idx,
    output logic [cnt_width(W+2)-1:0]      col_idx,
    output logic [cnt_width(W*H+1)-1:0]    win_count
);

    localparam int SP    = W + 2;
    localparam int RP    = H + 2;
    localparam int NWIN  = W * H;
    localparam int ROW_W = cnt_width(RP);
    localparam int COL_W = cnt_width(SP);
    localparam int WC_W  = cnt_width(NWIN + 1);
    localparam int FL_W  = cnt_width(FLUSH_LEN + 1);

    localparam logic [ROW_W-1:0] ROW_BODY_LAST = ROW_W'(H);
    localparam logic [WC_W-1:0]  NWIN_V        = WC_W'(NWIN);
    localparam logic [FL_W-1:0]  FL_LAST       = FL_W'(FLUSH_LEN - 1);

    conv_ctrl_state_t state, state_n;

    logic            cnt_clr, cnt_adv;
    logic            last_col, last_row;
    logic            interior;
    logic            frame_start;
    logic            flush_clr, flush_inc;
    logic [FL_W-1:0] flush_cnt;
    logic [M-1:0]    din_n;
    logic            valid_n, repeat_n, busy_n, done_n;

    conv_pad_cnt #(
        .SP    (SP),
        .RP    (RP),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_pad_cnt (
        .clk      (clk),
        .Rst_n    (Rst_n),
        .clr      (cnt_clr),
        .adv      (cnt_adv),
        .row      (row_idx),
        .col      (col_idx),
        .last_col (last_col),
        .last_row (last_row)
    );

    // Interior body columns are the only ones that consume upstream pixels.
    assign interior = (col_idx != '0) && !last_col;
    assign s_ready  = (state == ST_BODY) && interior;

    // A start coinciding with the done pulse belongs to the finished frame and is dropped.
    assign frame_start = (state == ST_IDLE) && start && !done && !abort;

    // State register.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, counter control and next values of the registered outputs.
    always_comb begin
        state_n   = state;
        cnt_clr   = 1'b0;
        cnt_adv   = 1'b0;
        flush_clr = 1'b0;
        flush_inc = 1'b0;
        din_n     = '0;
        valid_n   = 1'b0;
        repeat_n  = 1'b0;
        busy_n    = busy;
        done_n    = 1'b0;
        if (abort) begin
            state_n   = ST_IDLE;
            cnt_clr   = 1'b1;
            flush_clr = 1'b1;
            busy_n    = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        state_n = ST_PAD_TOP;
                        cnt_clr = 1'b1;
                        busy_n  = 1'b1;
                    end
                end
                ST_PAD_TOP: begin
                    valid_n = 1'b1;
                    cnt_adv = 1'b1;
                    if (last_col) begin
                        state_n = ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (!interior) begin
                        valid_n = 1'b1;
                        cnt_adv = 1'b1;
                        if (last_col && row_idx == ROW_BODY_LAST) begin
                            state_n = ST_PAD_BOT;
                        end
                    end else if (s_valid) begin
                        valid_n = 1'b1;
                        din_n   = s_data;
                        cnt_adv = 1'b1;
                    end
                end
                ST_PAD_BOT: begin
                    valid_n = 1'b1;
                    cnt_adv = 1'b1;
                    if (last_col && last_row) begin
                        state_n   = ST_FLUSH;
                        flush_clr = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    repeat_n  = 1'b1;
                    flush_inc = 1'b1;
                    if (flush_cnt == FL_LAST) begin
                        state_n = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (win_count == NWIN_V) begin
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = ST_IDLE;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    busy_n  = 1'b0;
                end
            endcase
        end
    end

    // Output register: each selected column shows up on the window inputs one cycle later.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            win_din    <= '0;
            win_valid  <= 1'b0;
            win_repeat <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            win_din    <= din_n;
            win_valid  <= valid_n;
            win_repeat <= repeat_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

    // Counts repeat cycles spent in FLUSH.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            flush_cnt <= '0;
        end else if (flush_clr) begin
            flush_cnt <= '0;
        end else if (flush_inc) begin
            flush_cnt <= flush_cnt + 1'b1;
        end
    end

    // Window counter: counts generator outputs while busy, saturating at the frame total.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            win_count <= '0;
        end else if (abort || frame_start) begin
            win_count <= '0;
        end else if (busy && win_valid_out && win_count != NWIN_V) begin
            win_count <= win_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb/tb_conv_window_ctrl.sv - self-checking bench for conv_window_ctrl
module tb_conv_window_ctrl;

    logic       clk;
    logic       Rst_n;
    logic       start;
    logic       abort;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] win_din;
    logic       win_valid;
    logic       win_repeat;
    logic       win_valid_out;
    logic       busy;
    logic       done;
    logic [2:0] row_idx;
    logic [2:0] col_idx;
    logic [3:0] win_count;

    conv_window_ctrl #(.M(8), .W(4), .H(3), .FLUSH_LEN(6)) dut (
        .clk           (clk),
        .Rst_n         (Rst_n),
        .start         (start),
        .abort         (abort),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .win_din       (win_din),
        .win_valid     (win_valid),
        .win_repeat    (win_repeat),
        .win_valid_out (win_valid_out),
        .busy          (busy),
        .done          (done),
        .row_idx       (row_idx),
        .col_idx       (col_idx),
        .win_count     (win_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       stall;
        logic [7:0] base;
        int         gen_limit;
        logic       hold;
        logic       start_body;
        logic       start_done;
        int         exp_span;
        int         exp_srdy;
    } vec_t;

    vec_t vecs[4];

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    int   cyc, beat, first_beat, last_beat, first_rep, reps, srdy, idx;
    int   dones, done_busy, overlap, stall_err, gens, gen_limit, hold_left, max_wc;
    int   abort_at;
    logic gen_en, wvo_next, hold_req, prev_stall, stall_mode;
    logic abort_fired, start_body_req, start_done_req, start_done_hit;
    logic [7:0] base;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic frame_init(input logic [7:0] b, input logic stl, input int lim, input logic hld);
        exp_q.delete();
        cyc = 0; beat = 0; first_beat = -1; last_beat = -1; first_rep = -1;
        reps = 0; srdy = 0; idx = 0; dones = 0; done_busy = 0; overlap = 0;
        stall_err = 0; gens = 0; max_wc = 0; hold_left = 0;
        base = b; stall_mode = stl; gen_limit = lim; hold_req = hld;
        gen_en = 1'b1; wvo_next = 1'b0; prev_stall = 1'b0;
        abort_fired = 1'b0; start_done_hit = 1'b0;
        start_body_req = 1'b0; start_done_req = 1'b0;
    endtask

    task automatic push_expected(input logic [7:0] b);
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 6; c++) begin
                if (r == 0 || r == 4 || c == 0 || c == 5) exp_q.push_back(8'h00);
                else exp_q.push_back(8'(int'(b) + (r - 1) * 4 + (c - 1)));
            end
        end
    endtask

    // One clock: sample outputs at the falling edge, then drive inputs for the next rising edge.
    task automatic tick();
        int r, c;
        logic [7:0] e;
        @(negedge clk);
        cyc++;
        wvo_next = 1'b0;
        if (win_valid) begin
            if (first_beat < 0) first_beat = cyc;
            last_beat = cyc;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check($sformatf("win_din beat%0d", beat), win_din, e);
            end
            r = beat / 6;
            c = beat % 6;
            if (gen_en && gens < gen_limit && r >= 2 && c >= 2) begin
                wvo_next = 1'b1;
                gens++;
            end
            beat++;
        end
        if (win_valid && win_repeat) overlap++;
        if (win_repeat) begin
            reps++;
            if (first_rep < 0) first_rep = cyc;
            if (hold_req) begin
                hold_left = 20;
                hold_req = 1'b0;
            end
        end
        if (prev_stall && win_valid) stall_err++;
        if (done) begin
            dones++;
            if (busy) done_busy++;
        end
        if (int'(win_count) > max_wc) max_wc = int'(win_count);
        if (s_ready) srdy++;

        start = 1'b0;
        abort = 1'b0;
        win_valid_out = wvo_next || (hold_left > 0);
        if (hold_left > 0) hold_left--;
        s_valid = stall_mode ? (cyc % 2 == 1) : 1'b1;
        s_data = 8'(int'(base) + idx);
        prev_stall = s_ready && !s_valid;
        if (s_ready && s_valid) begin
            if (abort_at > 0 && idx == abort_at - 1) begin
                abort = 1'b1;
                abort_fired = 1'b1;
            end
            idx++;
        end
        if (start_body_req && busy && row_idx == 3'd2) begin
            start = 1'b1;
            start_body_req = 1'b0;
        end
        if (start_done_req && done) begin
            start = 1'b1;
            start_done_req = 1'b0;
            start_done_hit = 1'b1;
        end
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        frame_init(v.base, v.stall, v.gen_limit, v.hold);
        start_body_req = v.start_body;
        start_done_req = v.start_done;
        push_expected(v.base);
        start = 1'b1;
        while (dones == 0 && cyc < 300) tick();
        check({tag, " done_seen"}, dones, 1);
        repeat (6) tick();
        check({tag, " beats"}, beat, 30);
        check({tag, " leftover"}, exp_q.size(), 0);
        check({tag, " first_beat_lat"}, first_beat, 2);
        if (v.exp_span > 0) check({tag, " pixel_span"}, last_beat - first_beat + 1, v.exp_span);
        if (v.exp_srdy > 0) check({tag, " s_ready_cycles"}, srdy, v.exp_srdy);
        check({tag, " accepted"}, idx, 12);
        check({tag, " repeat_cycles"}, reps, 6);
        check({tag, " repeat_follows"}, first_rep, last_beat + 1);
        check({tag, " valid_repeat_overlap"}, overlap, 0);
        check({tag, " stall_valid"}, stall_err, 0);
        check({tag, " done_pulses"}, dones, 1);
        check({tag, " busy_at_done"}, done_busy, 0);
        check({tag, " win_count_max"}, max_wc, 12);
        check({tag, " win_count_end"}, win_count, 12);
        check({tag, " busy_after"}, busy, 0);
        if (v.start_done) check({tag, " start_at_done_issued"}, start_done_hit, 1);
    endtask

    initial begin
        vecs[0] = '{stall: 1'b0, base: 8'h01, gen_limit: 12, hold: 1'b0, start_body: 1'b0, start_done: 1'b0, exp_span: 30, exp_srdy: 12};
        vecs[1] = '{stall: 1'b1, base: 8'h40, gen_limit: 12, hold: 1'b0, start_body: 1'b0, start_done: 1'b0, exp_span: 0,  exp_srdy: 0};
        vecs[2] = '{stall: 1'b0, base: 8'hA0, gen_limit: 8,  hold: 1'b1, start_body: 1'b0, start_done: 1'b0, exp_span: 30, exp_srdy: 12};
        vecs[3] = '{stall: 1'b0, base: 8'h10, gen_limit: 12, hold: 1'b0, start_body: 1'b1, start_done: 1'b1, exp_span: 30, exp_srdy: 12};

        Rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_data = '0; s_valid = 1'b0;
        win_valid_out = 1'b0; abort_at = 0;
        frame_init(8'h00, 1'b0, 0, 1'b0);
        tick();
        tick();
        check("reset busy", busy, 0);
        check("reset win_valid", win_valid, 0);
        check("reset s_ready", s_ready, 0);
        check("reset win_count", win_count, 0);
        Rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Asynchronous reset in the middle of the body rows.
        frame_init(8'h30, 1'b0, 12, 1'b0);
        start = 1'b1;
        while (row_idx != 3'd3 && cyc < 200) tick();
        check("rst_mid reached_row3", row_idx, 3);
        #1;
        Rst_n = 1'b0;
        #1;
        check("rst_mid busy", busy, 0);
        check("rst_mid win_valid", win_valid, 0);
        check("rst_mid win_din", win_din, 0);
        check("rst_mid win_repeat", win_repeat, 0);
        check("rst_mid done", done, 0);
        check("rst_mid row", row_idx, 0);
        check("rst_mid col", col_idx, 0);
        check("rst_mid win_count", win_count, 0);
        check("rst_mid s_ready", s_ready, 0);
        win_valid_out = 1'b0;
        @(negedge clk);
        Rst_n = 1'b1;
        run_frame(vecs[0], "post_reset");

        // Abort on the third body pixel.
        frame_init(8'h20, 1'b0, 12, 1'b0);
        abort_at = 3;
        start = 1'b1;
        while (!abort_fired && cyc < 200) tick();
        check("abort fired", abort_fired, 1);
        abort_at = 0;
        tick();
        check("abort busy", busy, 0);
        check("abort win_valid", win_valid, 0);
        check("abort win_repeat", win_repeat, 0);
        check("abort done", done, 0);
        check("abort win_count", win_count, 0);
        check("abort col", col_idx, 0);
        repeat (10) tick();
        check("abort no_done", dones, 0);
        check("abort busy_later", busy, 0);
        run_frame(vecs[0], "post_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
